// File: rtl/hexdump_pkg.sv
// Shared types, ASCII constants and nibble encoder for the hex-text dump block.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
// Optional feature macro: HEXDUMP_TX_ADDR_EN adds the per-line address prefix states.
package hexdump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIG,
    LF,
    FIN
`ifdef HEXDUMP_TX_ADDR_EN
    ,
    AT,
    ADR,
    SP
`endif
  } state_t;

  localparam logic [7:0] ASC_LF      = 8'h0A;
  localparam logic [7:0] ASC_SP      = 8'h20;
  localparam logic [7:0] ASC_AT      = 8'h40;
  localparam logic [7:0] ASC_ZERO    = 8'h30;
  localparam logic [7:0] ASC_LOWER_A = 8'h61;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    if (n < 4'd10) return ASC_ZERO + {4'h0, n};
    else           return ASC_LOWER_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/hexdump_nib2asc.sv
// Combinational 4-bit to lowercase ASCII hex digit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: nib (4-bit value in), asc (ASCII byte out).
module hexdump_nib2asc
  import hexdump_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  assign asc = nib2asc(nib);

endmodule

// File: rtl/hexdump_tx.sv
// Capture buffer that dumps its words as lowercase hex text, one word per LF-terminated line.
// Latency: first byte valid the cycle after start is accepted; one byte per cycle when tx_ready is high.
// Backpressure: tx_valid/tx_data are registered and held while tx_ready is low; in_ready low while busy or full.
// Ports: clk, rst_n (async active-low); in_valid/in_data/in_ready capture stream; start pulse;
//        tx_valid/tx_data/tx_ready byte stream; busy, done pulse, count of captured words.
// Optional feature macro: HEXDUMP_TX_ADDR_EN prefixes each line with "@<addr> ".
module hexdump_tx
  import hexdump_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam int ND  = DW / 4;
  localparam int DIW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
`ifdef HEXDUMP_TX_ADDR_EN
  localparam int NA  = (ADDR_W + 3) / 4;
  localparam int AIW = (NA > 1) ? $clog2(NA) : 1;
`endif

  state_t            state, nxt_state;
  logic [DW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] rd_idx, nxt_rd_idx;
  logic [DIW-1:0]    dig, nxt_dig;
  logic [ADDR_W:0]   cnt_eff;
  logic              wr_en, hs;
  logic              nxt_tx_valid;
  logic [7:0]        nxt_tx_data;
  logic [DW-1:0]     word, word_sh;
  logic [7:0]        dasc;
  state_t            first_st;

`ifdef HEXDUMP_TX_ADDR_EN
  logic [AIW-1:0]    adr, nxt_adr;
  logic [NA*4-1:0]   adr_sh;
  logic [7:0]        aasc;
  assign first_st = AT;
`else
  assign first_st = DIG;
`endif

  assign in_ready = (state == IDLE) && (count < FULL);
  assign wr_en    = in_valid && in_ready;
  assign hs       = tx_valid && tx_ready;
  assign busy     = (state != IDLE);
  // A word captured in the same cycle as start belongs to this dump.
  assign cnt_eff  = count + {{ADDR_W{1'b0}}, wr_en};

  // Capture memory: written only in IDLE, so it is stable for the whole dump.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[ADDR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state == FIN) begin
      count <= '0;
    end else if (wr_en) begin
      count <= count + 1'b1;
    end
  end

  // State register plus registered byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_idx   <= '0;
      dig      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
`ifdef HEXDUMP_TX_ADDR_EN
      adr      <= '0;
`endif
    end else begin
      state    <= nxt_state;
      rd_idx   <= nxt_rd_idx;
      dig      <= nxt_dig;
      tx_valid <= nxt_tx_valid;
      tx_data  <= nxt_tx_data;
      done     <= (state == FIN);
`ifdef HEXDUMP_TX_ADDR_EN
      adr      <= nxt_adr;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    nxt_state  = state;
    nxt_rd_idx = rd_idx;
    nxt_dig    = dig;
`ifdef HEXDUMP_TX_ADDR_EN
    nxt_adr    = adr;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          nxt_rd_idx = '0;
          nxt_dig    = DIW'(ND - 1);
          nxt_state  = (cnt_eff == '0) ? FIN : first_st;
        end
      end
`ifdef HEXDUMP_TX_ADDR_EN
      AT: begin
        if (hs) begin
          nxt_state = ADR;
          nxt_adr   = AIW'(NA - 1);
        end
      end
      ADR: begin
        if (hs) begin
          if (adr == '0) nxt_state = SP;
          else           nxt_adr   = adr - 1'b1;
        end
      end
      SP: begin
        if (hs) nxt_state = DIG;
      end
`endif
      DIG: begin
        if (hs) begin
          if (dig == '0) nxt_state = LF;
          else           nxt_dig   = dig - 1'b1;
        end
      end
      LF: begin
        if (hs) begin
          if (((ADDR_W+1)'(rd_idx) + 1'b1) < count) begin
            nxt_state  = first_st;
            nxt_rd_idx = rd_idx + 1'b1;
            nxt_dig    = DIW'(ND - 1);
          end else begin
            nxt_state = FIN;
          end
        end
      end
      FIN:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Output logic: byte to present in the next state. Bypass covers a word
  // written on the same edge that start is accepted.
  assign word    = (wr_en && (count[ADDR_W-1:0] == nxt_rd_idx)) ? in_data : mem[nxt_rd_idx];
  assign word_sh = word >> (4 * nxt_dig);

  hexdump_nib2asc u_dig_asc (
    .nib (word_sh[3:0]),
    .asc (dasc)
  );

`ifdef HEXDUMP_TX_ADDR_EN
  assign adr_sh = (NA*4)'(nxt_rd_idx) >> (4 * nxt_adr);

  hexdump_nib2asc u_adr_asc (
    .nib (adr_sh[3:0]),
    .asc (aasc)
  );
`endif

  always_comb begin
    nxt_tx_valid = 1'b0;
    nxt_tx_data  = 8'h00;
    case (nxt_state)
      DIG: begin nxt_tx_valid = 1'b1; nxt_tx_data = dasc;   end
      LF:  begin nxt_tx_valid = 1'b1; nxt_tx_data = ASC_LF; end
`ifdef HEXDUMP_TX_ADDR_EN
      AT:  begin nxt_tx_valid = 1'b1; nxt_tx_data = ASC_AT; end
      ADR: begin nxt_tx_valid = 1'b1; nxt_tx_data = aasc;   end
      SP:  begin nxt_tx_valid = 1'b1; nxt_tx_data = ASC_SP; end
`endif
      default: begin nxt_tx_valid = 1'b0; nxt_tx_data = 8'h00; end
    endcase
  end

endmodule
